bcd_mult_gen: RTL and testbench
===============================

BCD_MULT_GEN -- requirements
Module: bcd_mult_gen

Interface
REQ-001 The module SHALL have ports clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have ports rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have port start, input, 1 bit: request to begin a sequence; sampled only in IDLE.
REQ-004 The module SHALL have port sel, input, 1 bit: 0 = multiples of 3, 1 = multiples of 11; sampled with start.
REQ-005 The module SHALL have port out_ready, input, 1 bit: the consumer accepts out_bcd this cycle.
REQ-006 The module SHALL have port out_bcd, output, 16 bits: 4-digit packed BCD, thousands in [15:12], units in [3:0].
REQ-007 The module SHALL have port out_valid, output, 1 bit: out_bcd holds a valid multiple.
REQ-008 The module SHALL have port busy, output, 1 bit: high in EMIT and DONE.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse after the last value is accepted.

Function
REQ-010 The module SHALL implement the states IDLE, EMIT and DONE in a registered FSM.
REQ-011 IDLE, start=1: the module SHALL latch sel, load value 0000 and enter EMIT on the next edge.
- out_valid=1 with out_bcd=0000 in the cycle after start.
REQ-012 IDLE, start=0: the module SHALL remain in IDLE with out_valid=0 and out_bcd held at its last value.
REQ-013 EMIT: the module SHALL hold out_valid=1.
REQ-014 A handshake SHALL occur in any cycle where out_valid=1 and out_ready=1.
REQ-015 While out_valid=1 and out_ready=0, out_bcd SHALL remain stable.
REQ-016 On a handshake in EMIT, the module SHALL register value + step, where step = 0003 (sel latched 0) or 0011 (sel latched 1).
- out_valid stays 1, so back-to-back handshakes give one value per cycle.
REQ-017 The addition SHALL be digit-wise BCD, units first, with the carry rippling upward.
- Per digit: s = a + b + cin; if s > 9, digit = s - 10 and cout = 1; otherwise digit = s and cout = 0.
REQ-018 If a handshake's addition produces a carry out of the thousands digit, or the accepted value is 9999, the module SHALL enter DONE instead of loading the new value.
REQ-019 The last value emitted SHALL be 9999 for both selections.
- sel=0 gives 3334 values; sel=1 gives 910 values.
REQ-020 DONE: the module SHALL drive done=1 and out_valid=0 for exactly one cycle, then return to IDLE.
REQ-021 start SHALL be ignored whenever busy=1.
- A change of sel mid-sequence SHALL have no effect.
REQ-022 A start asserted in the same cycle as done SHALL be ignored.
- A new sequence requires start while in IDLE.
REQ-023 Every value presented SHALL be valid BCD, with each digit at most 9.
- Every value presented SHALL be divisible by the selected divisor.

Reset
REQ-024 When rst=1 at a rising edge, the module SHALL enter IDLE regardless of state, including mid-sequence and during a stalled handshake.
REQ-025 The reset values SHALL be: out_bcd=0000, out_valid=0, busy=0, done=0, latched sel=0.
REQ-026 rst SHALL take priority over start and out_ready in the same cycle.
REQ-027 No partial sequence SHALL resume after reset.

Verification
REQ-028 Scenario, sel=0: start, out_ready=1 held -> 0000, 0003, 0006, 0009, 0012, ... one per cycle; 3334 values ending 9999; done pulses one cycle after 9999 is accepted; busy then falls.
REQ-029 Scenario, sel=1: start, out_ready=1 held -> 0000, 0011, 0022, ..., 0099, 0110, ..., 9988, 9999; 910 values; done pulses once.
REQ-030 Scenario, BCD carry: sel=0, run until 0096 -> next values 0099, 0102; sel=1 reaching 0990 -> next 1001.
REQ-031 Scenario, backpressure: out_ready toggled pseudo-randomly -> out_bcd is stable while stalled; no value is skipped or duplicated; the accepted-value stream is identical to the out_ready=1 run.
REQ-032 Scenario, reset mid-operation: rst=1 for one cycle at value 0450 with out_ready=0 -> the next cycle shows out_valid=0, busy=0, out_bcd=0000; a new start restarts at 0000.
REQ-033 Scenario, ignored starts: start pulsed during EMIT with sel flipped, and start in the done cycle -> the sequence is unchanged and no restart occurs.
REQ-034 Scenario, checker: every accepted out_bcd SHALL pass an independent divisibility-by-3 or divisibility-by-11 BCD check with no digit above 9.

Source files
------------

// File: rtl/bcd_mult_gen.sv
// bcd_mult_gen: emits the 4-digit packed-BCD multiples of 3 or 11, from 0000
// to 9999, one per valid/ready handshake, and then pulses done.

// One BCD digit of the adder. Takes two digits and a carry-in, and produces the
// sum digit and a carry-out.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] raw;
  logic [4:0] adj;

  // Add in binary. If the result is above 9, subtract 10 and set the carry.
  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    adj  = raw - 5'd10;
    sum  = raw[3:0];
    cout = 1'b0;
    if (raw > 5'd9) begin
      sum  = adj[3:0];
      cout = 1'b1;
    end
  end
endmodule

module bcd_mult_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sel,
  input  logic        out_ready,
  output logic [15:0] out_bcd,
  output logic        out_valid,
  output logic        busy,
  output logic        done
);
  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] val_q, val_d;
  logic        sel_q, sel_d;

  logic [15:0] step;
  logic [15:0] sum;
  logic [NUM_DIGITS:0] carry;

  assign step     = sel_q ? 16'h0011 : 16'h0003;
  assign carry[0] = 1'b0;

  // Ripple-carry BCD adder: one digit adder per digit, units digit first.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit_add u_add (
      .a    (val_q[4*g +: 4]),
      .b    (step[4*g +: 4]),
      .cin  (carry[g]),
      .sum  (sum[4*g +: 4]),
      .cout (carry[g+1])
    );
  end

  // Next state and next value. A handshake that would go past 9999 goes to DONE
  // and keeps the current value.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = sel;
          val_d   = 16'h0000;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (carry[NUM_DIGITS] || (val_q == 16'h9999)) begin
            state_d = DONE;
          end else begin
            val_d = sum;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset has priority over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      val_q   <= 16'h0000;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      sel_q   <= sel_d;
    end
  end

  // The outputs are decoded from the registered state only.
  always_comb begin
    out_bcd   = val_q;
    out_valid = (state_q == EMIT);
    busy      = (state_q == EMIT) || (state_q == DONE);
    done      = (state_q == DONE);
  end
endmodule

// File: tb/tb_bcd_mult_gen.sv
// Randomized bench for bcd_mult_gen. Expected values come from integer arithmetic
// that is converted to BCD, plus a separate digit-based divisibility checker.
module tb_bcd_mult_gen;
  logic        clk = 1'b0;
  logic        rst, start, sel, out_ready;
  logic [15:0] out_bcd;
  logic        out_valid, busy, done;

  int nvec = 0;
  int nerr = 0;

  bcd_mult_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sel       (sel),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Independent check: every digit is at most 9, and the value passes the
  // digit-sum rule for 3 or the alternating-sum rule for 11.
  function automatic logic div_ok(input logic [15:0] b, input logic s);
    int d[4];
    int alt;
    for (int i = 0; i < 4; i++) begin
      d[i] = int'(b[4*i +: 4]);
      if (d[i] > 9) return 1'b0;
    end
    if (!s) return ((d[0] + d[1] + d[2] + d[3]) % 3) == 0;
    alt = d[0] - d[1] + d[2] - d[3] + 22;
    return (alt % 11) == 0;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'b0, out_valid}, 0);
    chk({tag, "_busy"},  {31'b0, busy}, 0);
    chk({tag, "_done"},  {31'b0, done}, 0);
  endtask

  // Runs one full sequence. The model is a plain integer that steps by the
  // divisor on each accepted value.
  task automatic run_seq(input logic s, input int rdy_pct, input bit inject);
    int exp_v, div, n, cyc, exp_n;
    bit rdy;
    div   = s ? 11 : 3;
    exp_n = 9999 / div + 1;
    @(negedge clk);
    chk_idle("pre");
    start = 1'b1; sel = s; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    exp_v = 0; n = 0; cyc = 0;
    forever begin
      chk("valid", {31'b0, out_valid}, 1);
      chk("busy",  {31'b0, busy}, 1);
      chk("done",  {31'b0, done}, 0);
      chk("bcd",   {16'b0, out_bcd}, {16'b0, to_bcd(exp_v)});
      chk("divchk", {31'b0, div_ok(out_bcd, s)}, 1);
      rdy = ($urandom_range(99) < rdy_pct);
      out_ready = rdy;
      if (inject) begin
        start = $urandom_range(1);
        sel   = $urandom_range(1);
      end
      @(negedge clk);
      cyc++;
      if (rdy) begin
        n++;
        if (exp_v + div > 9999) break;
        exp_v += div;
      end
      if (cyc > 20000) begin
        chk("timeout", 1, 0);
        break;
      end
    end
    out_ready = $urandom_range(1);
    sel   = ~s;
    start = 1'b1;
    chk("count", n, exp_n);
    chk("last", exp_v, 9999);
    chk("d_done",  {31'b0, done}, 1);
    chk("d_valid", {31'b0, out_valid}, 0);
    chk("d_busy",  {31'b0, busy}, 1);
    @(negedge clk);
    start = 1'b0;
    chk_idle("post");
    chk("hold", {16'b0, out_bcd}, 32'h9999);
    @(negedge clk);
    chk_idle("post2");
  endtask

  initial begin
    int v;
    rst = 1'b1; start = 1'b0; sel = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("rst");
    chk("rst_bcd", {16'b0, out_bcd}, 0);
    rst = 1'b0;

    run_seq(1'b0, 100, 1'b0);
    run_seq(1'b1, 100, 1'b0);
    run_seq(1'b0, 50, 1'b1);
    run_seq(1'b1, 35, 1'b1);

    // Reset in the middle of a sequence, with the output stalled at 0450.
    @(negedge clk);
    start = 1'b1; sel = 1'b0;
    @(negedge clk);
    start = 1'b0;
    v = 0;
    while (v != 450) begin
      chk("r_bcd", {16'b0, out_bcd}, {16'b0, to_bcd(v)});
      out_ready = 1'b1;
      @(negedge clk);
      v += 3;
    end
    chk("r_at450", {16'b0, out_bcd}, 32'h0450);
    out_ready = 1'b0; rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk_idle("mrst");
    chk("mrst_bcd", {16'b0, out_bcd}, 0);
    @(negedge clk);
    chk_idle("mrst2");
    run_seq(1'b0, 70, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
